// File: rtl/synfull_inj_queue_pkg.sv
// Shared types for the SynFull injection queue: request/delivery records and the stored entry.
package synfull_inj_queue_pkg;

    localparam int SYNFULL_IDW          = 32;
    localparam int SYNFULL_PCK_SIZW     = 9;
    localparam int SYNFULL_NEW          = 6;
    localparam int SYNFULL_MIN_PCK_SIZE = 2;

    typedef struct packed {
        logic                          valid;
        logic [SYNFULL_IDW-1:0]        id;
        logic [SYNFULL_PCK_SIZW-1:0]   size;
        logic [SYNFULL_NEW-1:0]        dest;
    } req_t;

    typedef struct packed {
        logic                          pck_wr;
        logic [SYNFULL_IDW-1:0]        data;
        logic [SYNFULL_PCK_SIZW-1:0]   size;
        logic [SYNFULL_NEW-1:0]        dest;
    } deliver_t;

    typedef struct packed {
        logic [SYNFULL_IDW-1:0]        id;
        logic [SYNFULL_PCK_SIZW-1:0]   size;
        logic [SYNFULL_NEW-1:0]        dest;
    } inj_entry_t;

endpackage

// File: rtl/synfull_inj_queue_ram.sv
// Simple dual-port entry store: synchronous write, asynchronous read so the head is visible
// one cycle after it is written.
module synfull_inj_queue_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 47,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/synfull_inj_queue.sv
// Per-endpoint injection queue between SynFull requests and the packet injector, with an
// empty/ready bypass. Statistics (drop_count, max_occ) are built only with SYNFULL_INJ_QUEUE_STAT_EN.
module synfull_inj_queue
    import synfull_inj_queue_pkg::*;
#(
    parameter int DEPTH        = 64,
    parameter int IDw          = 32,
    parameter int PCK_SIZw     = 9,
    parameter int NEw          = 6,
    parameter int MIN_PCK_SIZE = SYNFULL_MIN_PCK_SIZE
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    input  logic [IDw-1:0]             req_id,
    input  logic [PCK_SIZw-1:0]        req_size,
    input  logic [NEw-1:0]             req_dest,
    input  logic                       inj_ready,
    output logic                       inj_wr,
    output logic [IDw-1:0]             inj_id,
    output logic [PCK_SIZw-1:0]        inj_size,
    output logic [NEw-1:0]             inj_dest,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       full,
    output logic                       overflow,
    output logic                       size_err,
    output logic [31:0]                drop_count,
    output logic [$clog2(DEPTH+1)-1:0] max_occ
);

    localparam int PTRw = $clog2(DEPTH);
    localparam int OCCw = $clog2(DEPTH+1);
    localparam int ENTw = IDw + PCK_SIZw + NEw;
    localparam logic [PTRw-1:0]     PTR_LAST = PTRw'(DEPTH - 1);
    localparam logic [OCCw-1:0]     OCC_FULL = OCCw'(DEPTH);
    localparam logic [PCK_SIZw-1:0] SIZE_MIN = PCK_SIZw'(MIN_PCK_SIZE);

    logic [PTRw-1:0]     rd_ptr, wr_ptr;
    logic [OCCw-1:0]     occ_q, occ_nxt;
    logic                empty, bypass, pop, push, drop, size_small;
    logic [PCK_SIZw-1:0] req_size_c;
    logic [ENTw-1:0]     wr_entry, head_entry;
    logic                overflow_q, size_err_q;

    // DEPTH need not be a power of two, so wrap by compare rather than by mask
    function automatic logic [PTRw-1:0] ptr_inc(input logic [PTRw-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTRw'(1);
    endfunction

    assign empty      = (occ_q == '0);
    assign full       = (occ_q == OCC_FULL);
    assign bypass     = empty && req_valid && inj_ready;
    assign pop        = inj_ready && !empty;
    assign push       = req_valid && !bypass && (!full || pop);
    assign drop       = req_valid && !bypass && full && !pop;
    assign size_small = (req_size < SIZE_MIN);
    assign req_size_c = size_small ? SIZE_MIN : req_size;
    assign wr_entry   = {req_id, req_size_c, req_dest};

    assign inj_wr = reset && inj_ready && (!empty || req_valid);
    assign {inj_id, inj_size, inj_dest} = empty ? wr_entry : head_entry;

    always_comb begin
        occ_nxt = occ_q;
        if (push && !pop) begin
            occ_nxt = occ_q + OCCw'(1);
        end else if (pop && !push) begin
            occ_nxt = occ_q - OCCw'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            occ_q      <= '0;
            overflow_q <= 1'b0;
            size_err_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            occ_q <= occ_nxt;
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if ((push || bypass) && size_small) begin
                size_err_q <= 1'b1;
            end
        end
    end

    synfull_inj_queue_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTw),
        .AW    (PTRw)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push && reset),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr),
        .rd_data (head_entry)
    );

    assign occupancy = occ_q;
    assign overflow  = overflow_q;
    assign size_err  = size_err_q;

`ifdef SYNFULL_INJ_QUEUE_STAT_EN
    logic [31:0]     drop_cnt_q;
    logic [OCCw-1:0] max_occ_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            drop_cnt_q <= '0;
            max_occ_q  <= '0;
        end else begin
            if (drop && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + 32'd1;
            end
            if (occ_nxt > max_occ_q) begin
                max_occ_q <= occ_nxt;
            end
        end
    end

    assign drop_count = drop_cnt_q;
    assign max_occ    = max_occ_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset && drop) begin
            $display("%0t %m: request dropped, id %0h dest %0d", $time, req_id, req_dest);
        end
    end
`endif
`else
    assign drop_count = '0;
    assign max_occ    = '0;
`endif

endmodule
